pulse_stretcher: RTL and testbench

//  Output-side counterpart to input debouncing: turns single-cycle events into clean,

---
 rtl/pulse_stretcher_pkg.sv | 10 +
 rtl/pulse_stretcher_if.sv | 11 +
 rtl/pulse_stretcher_cycle_timer.sv | 18 +
 rtl/pulse_stretcher.sv | 82 ++++++++
 tb/tb_pulse_stretcher.sv | 132 +++++++++++++
 5 files changed

// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg: shared state type and timing helpers for the pulse stretcher
package pulse_stretcher_pkg;
    typedef enum logic [1:0] {IDLE, ON, OFF} ps_state_t;
    function automatic int us_to_cycles(input int us, input int clk_period_ns);
        return (us * 1000 + clk_period_ns - 1) / clk_period_ns;
    endfunction
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if: event request / stretched pulse signal bundle
interface pulse_stretcher_if #(parameter int PEND_W = 2);
    logic              trigger_in;
    logic              clear_in;
    logic              pulse_out;
    logic              busy_out;
    logic [PEND_W-1:0] pending_out;
    logic              dropped_out;
    modport master (output trigger_in, clear_in, input pulse_out, busy_out, pending_out, dropped_out);
    modport slave  (input trigger_in, clear_in, output pulse_out, busy_out, pending_out, dropped_out);
endinterface

// File: rtl/pulse_stretcher_cycle_timer.sv
// cycle_timer: loadable down-counter, done_out while the count sits at zero
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_val_in,
    output logic             done_out
);
    logic [WIDTH-1:0] r_count;
    always_ff @(posedge clk_in) begin
        if (!rst_in)               r_count <= '0;
        else if (load_in)          r_count <= load_val_in;
        else if (r_count != '0)    r_count <= r_count - 1'b1;
    end
    assign done_out = r_count == '0;
endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches trigger events into fixed-width pulses with a forced low gap,
// queueing events that arrive while a pulse or gap is in progress.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int CLK_PERIOD_NS = 10,
    parameter int ON_TIME_US    = 500,
    parameter int OFF_TIME_US   = 500,
    parameter int PENDING_MAX   = 3,
    localparam int PEND_W       = $clog2(PENDING_MAX + 1)
) (
    input logic                clk_in,
    input logic                rst_in,
    pulse_stretcher_if.slave   bus
);
    localparam int ON_CYCLES  = us_to_cycles(ON_TIME_US, CLK_PERIOD_NS);
    localparam int OFF_CYCLES = us_to_cycles(OFF_TIME_US, CLK_PERIOD_NS);
    localparam int TW         = max2(1, $clog2(max2(ON_CYCLES, OFF_CYCLES)));
    localparam logic [TW-1:0] ON_VAL  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_VAL = TW'(OFF_CYCLES - 1);

    if (ON_CYCLES < 1 || OFF_CYCLES < 1 || PENDING_MAX < 1) begin : g_param_check
        $error("pulse_stretcher: ON/OFF cycles and PENDING_MAX must be at least 1");
    end

    ps_state_t         r_state, w_next;
    logic [PEND_W-1:0] r_pending, w_pending_next;
    logic              r_pulse, r_busy, r_dropped;
    logic              w_busy, w_done, w_last_off, w_replay, w_restart, w_full, w_drop, w_load;
    logic [TW-1:0]     w_load_val;

    cycle_timer #(.WIDTH(TW)) u_timer (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .load_in     (w_load),
        .load_val_in (w_load_val),
        .done_out    (w_done)
    );

    always_comb begin
        w_busy     = r_state != IDLE;
        w_full     = r_pending == PEND_W'(PENDING_MAX);
        w_last_off = r_state == OFF && w_done;
        w_replay   = w_last_off && !bus.clear_in && r_pending != '0;
        // a trigger on the last gap cycle with nothing queued is replayed directly
        w_restart  = w_last_off && !bus.clear_in && (r_pending != '0 || bus.trigger_in);
        w_next     = r_state == IDLE ? (bus.trigger_in ? ON : IDLE) :
                     r_state == ON   ? (w_done ? OFF : ON) :
                     w_last_off      ? (w_restart ? ON : IDLE) : OFF;
        w_load     = w_next != r_state;
        w_load_val = w_next == OFF ? OFF_VAL : ON_VAL;
        w_drop     = w_busy && bus.trigger_in && !bus.clear_in && !w_last_off && w_full;
        w_pending_next = bus.clear_in ? '0 :
                         w_replay ? r_pending - PEND_W'(!bus.trigger_in) :
                         (w_busy && !w_last_off && bus.trigger_in && !w_full) ? r_pending + 1'b1 :
                         r_pending;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_pending <= '0;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_pulse   <= w_next == ON;
            r_busy    <= w_next != IDLE;
            r_dropped <= w_drop;
        end
    end

    assign bus.pulse_out   = r_pulse;
    assign bus.busy_out    = r_busy;
    assign bus.pending_out = r_pending;
    assign bus.dropped_out = r_dropped;
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: directed and random stimulus against a timestamp-window reference model
module tb_pulse_stretcher;
    localparam int ON = 100, OFF = 100, PMAX = 2, PW = $clog2(PMAX + 1);

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    pulse_stretcher_if #(.PEND_W(PW)) bus ();

    pulse_stretcher #(
        .CLK_PERIOD_NS (10),
        .ON_TIME_US    (1),
        .OFF_TIME_US   (1),
        .PENDING_MAX   (PMAX)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int n_vec = 0, n_bad = 0;
    int cyc = 0, s = 0, pend = 0, peak = 0, rises = 0, drops = 0;
    bit act = 0, drop = 0, prev_pulse = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    // model: an active window of ON+OFF cycles starting at s; events queue while active
    task automatic step(input bit tr, input bit cl, input bit rn);
        @(negedge clk_in);
        bus.trigger_in = tr;
        bus.clear_in   = cl;
        rst_in         = rn;
        @(posedge clk_in);
        if (!rn) begin
            act = 0; pend = 0; drop = 0;
        end else begin
            drop = 0;
            if (!act) begin
                if (tr) begin act = 1; s = cyc + 1; end
            end else if (cyc == s + ON + OFF - 1) begin
                if (!cl && (pend > 0 || tr)) begin
                    s = cyc + 1;
                    if (pend > 0 && !tr) pend--;
                end else act = 0;
                if (cl) pend = 0;
            end else if (cl) pend = 0;
            else if (tr) begin
                if (pend < PMAX) pend++;
                else drop = 1;
            end
        end
        cyc++;
        #1;
        chk("pulse",   bus.pulse_out,   act && (cyc - s) < ON);
        chk("busy",    bus.busy_out,    act);
        chk("pending", bus.pending_out, pend);
        chk("dropped", bus.dropped_out, drop);
        if (bus.pulse_out === 1'b1 && !prev_pulse) rises++;
        prev_pulse = bus.pulse_out === 1'b1;
        if (bus.dropped_out === 1'b1) drops++;
        if (bus.pending_out > peak) peak = bus.pending_out;
    endtask

    task automatic clr_stats();
        rises = 0; drops = 0; peak = 0;
    endtask

    initial begin
        bus.trigger_in = 1'b0;
        bus.clear_in   = 1'b0;
        repeat (3) step(0, 0, 0);
        repeat (5) step(0, 0, 1);

        clr_stats();
        for (int i = 0; i < 210; i++) step(i == 0, 0, 1);
        chk("single_rises", rises, 1);
        chk("single_peak", peak, 0);

        clr_stats();
        for (int i = 0; i < 610; i++) step(i == 0 || i == 50 || i == 150, 0, 1);
        chk("three_rises", rises, 3);
        chk("three_peak", peak, 2);
        chk("three_idle_pend", bus.pending_out, 0);

        clr_stats();
        for (int i = 0; i < 610; i++) step(i % 10 == 0 && i <= 40, 0, 1);
        chk("ovf_drops", drops, 2);
        chk("ovf_rises", rises, 3);
        chk("ovf_peak", peak, 2);

        clr_stats();
        for (int i = 0; i < 810; i++) begin
            step(i == 0 || i == 10 || i == 20 || i == 200, 0, 1);
            if (i == 200) chk("lastoff_pend", bus.pending_out, 2);
            if (i == 200) chk("lastoff_pulse", bus.pulse_out, 1);
        end
        chk("lastoff_drops", drops, 0);
        chk("lastoff_rises", rises, 4);

        clr_stats();
        for (int i = 0; i < 260; i++) begin
            step(i == 0 || i == 10 || i == 20 || i == 150, i == 150, 1);
            if (i == 150) chk("clear_pend", bus.pending_out, 0);
        end
        chk("clear_rises", rises, 1);
        chk("clear_drops", drops, 0);
        chk("clear_busy", bus.busy_out, 0);

        clr_stats();
        for (int i = 0; i < 45; i++) step(i == 0 || i == 5, 0, i != 40);
        chk("rst_pulse", bus.pulse_out, 0);
        chk("rst_pend", bus.pending_out, 0);

        for (int i = 0; i < 8000; i++) begin
            bit tr, cl;
            tr = (i < 4000) ? ($urandom % 40 == 0) : ($urandom % 6 == 0);
            cl = $urandom % 64 == 0;
            if (!act && cl) tr = 0;
            step(tr, cl, $urandom % 900 != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
